l2_mem_bridge: RTL and testbench

L2_MEM_BRIDGE -- requirements
Module: l2_mem_bridge

---
 rtl/l2_mem_bridge.sv | 190 +++++++++++++++++++
 tb/tb_l2_mem_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_bridge.sv
// l2_mem_bridge: serves inst/data L2 writeback and fill requests as
// word-by-word transfers to memory, one line at a time.
// Ports: clk_l2/rst; inst_*/data_* request sets (dirty=writeback,
// replace=fill, line addresses, done pulses); wb_rd_* L2 read port;
// fill_* L2 write port; mem_* word request/ack memory port.
module l2_mem_bridge #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                          clk_l2,
   input  logic                          rst,
   input  logic                          inst_mem_dirty_req,
   input  logic                          inst_mem_replace_req,
   input  logic [ADDR_W-1:0]             inst_dirty_addr,
   input  logic [ADDR_W-1:0]             inst_fill_addr,
   output logic                          inst_mem_dirty_done,
   output logic                          inst_mem_replace_done,
   input  logic                          data_mem_dirty_req,
   input  logic                          data_mem_replace_req,
   input  logic [ADDR_W-1:0]             data_dirty_addr,
   input  logic [ADDR_W-1:0]             data_fill_addr,
   output logic                          data_mem_dirty_done,
   output logic                          data_mem_replace_done,
   output logic                          wb_rd_sel,
   output logic [$clog2(LINE_WORDS)-1:0] wb_rd_idx,
   input  logic [DATA_W-1:0]             wb_rd_data,
   output logic                          fill_we,
   output logic                          fill_sel,
   output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
   output logic [DATA_W-1:0]             fill_data,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic                          mem_ack,
   input  logic [DATA_W-1:0]             mem_rdata
);

   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam int BSH   = $clog2(DATA_W / 8);
   localparam int LSH   = $clog2(LINE_WORDS * DATA_W / 8);
   localparam logic [ADDR_W-1:0] LMASK =
      ~((ADDR_W'(1) << LSH) - ADDR_W'(1));
   localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, ARB, WB_RD, WB_WR, FILL, DONE
   } state_e;

   state_e state_q, state_d;

   // Flag order: 0 i_dirty, 1 i_fill, 2 d_dirty, 3 d_fill, so
   // index = {sel, is_fill}.
   logic [3:0]        req_in, req_q, arm_q;
   logic [3:0]        pend_q, pend_d, cap, clr;
   logic [ADDR_W-1:0] addr_in [4];
   logic [ADDR_W-1:0] addr_q  [4];

   logic              rr_q, sel_q, fill_q, first_q;
   logic [IDX_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] line_q, cur_addr;
   logic [DATA_W-1:0] wdata_q;
   logic              i_any, d_any, gsel, gfill, last;
   logic [1:0]        gidx, sidx;

   assign req_in = {data_mem_replace_req, data_mem_dirty_req,
                    inst_mem_replace_req, inst_mem_dirty_req};

   assign addr_in[0] = inst_dirty_addr;
   assign addr_in[1] = inst_fill_addr;
   assign addr_in[2] = data_dirty_addr;
   assign addr_in[3] = data_fill_addr;

   // rr_q=1 gives data priority; the other side wins only if the
   // preferred one has nothing pending.
   assign i_any = |pend_q[1:0];
   assign d_any = |pend_q[3:2];
   assign gsel  = rr_q ? d_any : ~i_any;
   assign gfill = gsel ? ~pend_q[2] : ~pend_q[0];
   assign gidx  = {gsel, gfill};
   assign sidx  = {sel_q, fill_q};

   // arm_q blocks levels held through reset until they drop once.
   // A fresh edge during DONE of the same flag re-arms it.
   assign clr    = (state_q == DONE) ? (4'b0001 << sidx) : 4'b0000;
   assign cap    = req_in & ~req_q & arm_q & (~pend_q | clr);
   assign pend_d = (pend_q & ~clr) | cap;

   assign last     = (cnt_q == LAST);
   assign cur_addr = line_q + (ADDR_W'(cnt_q) << BSH);

   always_ff @(posedge clk_l2) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         arm_q   <= '0;
         pend_q  <= '0;
         rr_q    <= 1'b1;
         sel_q   <= 1'b0;
         fill_q  <= 1'b0;
         first_q <= 1'b0;
         cnt_q   <= '0;
         line_q  <= '0;
         wdata_q <= '0;
         for (int i = 0; i < 4; i++) addr_q[i] <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_in;
         arm_q   <= arm_q | ~req_in;
         pend_q  <= pend_d;
         for (int i = 0; i < 4; i++)
            if (cap[i]) addr_q[i] <= addr_in[i] & LMASK;
         // Array read data shows up in the first WB_WR cycle only.
         first_q <= (state_q == WB_RD);
         if (first_q) wdata_q <= wb_rd_data;
         case (state_q)
            ARB: begin
               sel_q  <= gsel;
               fill_q <= gfill;
               rr_q   <= ~gsel;
               line_q <= addr_q[gidx];
               cnt_q  <= '0;
            end
            WB_WR, FILL: begin
               if (mem_ack && !last) cnt_q <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d               = state_q;
      wb_rd_sel             = 1'b0;
      wb_rd_idx             = '0;
      fill_we               = 1'b0;
      fill_sel              = 1'b0;
      fill_idx              = '0;
      fill_data             = '0;
      mem_req               = 1'b0;
      mem_we                = 1'b0;
      mem_addr              = '0;
      mem_wdata             = '0;
      inst_mem_dirty_done   = 1'b0;
      inst_mem_replace_done = 1'b0;
      data_mem_dirty_done   = 1'b0;
      data_mem_replace_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (|pend_q) state_d = ARB;
         end
         ARB: begin
            state_d = gfill ? FILL : WB_RD;
         end
         WB_RD: begin
            wb_rd_sel = sel_q;
            wb_rd_idx = cnt_q;
            state_d   = WB_WR;
         end
         WB_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cur_addr;
            mem_wdata = first_q ? wb_rd_data : wdata_q;
            if (mem_ack) state_d = last ? DONE : WB_RD;
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = cur_addr;
            if (mem_ack) begin
               fill_we   = 1'b1;
               fill_sel  = sel_q;
               fill_idx  = cnt_q;
               fill_data = mem_rdata;
               state_d   = last ? DONE : FILL;
            end
         end
         DONE: begin
            inst_mem_dirty_done   = (sidx == 2'd0);
            inst_mem_replace_done = (sidx == 2'd1);
            data_mem_dirty_done   = (sidx == 2'd2);
            data_mem_replace_done = (sidx == 2'd3);
            state_d               = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_l2_mem_bridge.sv
// tb_l2_mem_bridge: directed + random stimulus for l2_mem_bridge,
// checked against an expected-transfer queue built from line rules.
module tb_l2_mem_bridge;

   logic        clk_l2 = 1'b0;
   logic        rst;
   logic        inst_mem_dirty_req, inst_mem_replace_req;
   logic [31:0] inst_dirty_addr, inst_fill_addr;
   logic        inst_mem_dirty_done, inst_mem_replace_done;
   logic        data_mem_dirty_req, data_mem_replace_req;
   logic [31:0] data_dirty_addr, data_fill_addr;
   logic        data_mem_dirty_done, data_mem_replace_done;
   logic        wb_rd_sel;
   logic [1:0]  wb_rd_idx;
   logic [31:0] wb_rd_data;
   logic        fill_we, fill_sel;
   logic [1:0]  fill_idx;
   logic [31:0] fill_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   l2_mem_bridge dut (
      .clk_l2                (clk_l2),
      .rst                   (rst),
      .inst_mem_dirty_req    (inst_mem_dirty_req),
      .inst_mem_replace_req  (inst_mem_replace_req),
      .inst_dirty_addr       (inst_dirty_addr),
      .inst_fill_addr        (inst_fill_addr),
      .inst_mem_dirty_done   (inst_mem_dirty_done),
      .inst_mem_replace_done (inst_mem_replace_done),
      .data_mem_dirty_req    (data_mem_dirty_req),
      .data_mem_replace_req  (data_mem_replace_req),
      .data_dirty_addr       (data_dirty_addr),
      .data_fill_addr        (data_fill_addr),
      .data_mem_dirty_done   (data_mem_dirty_done),
      .data_mem_replace_done (data_mem_replace_done),
      .wb_rd_sel             (wb_rd_sel),
      .wb_rd_idx             (wb_rd_idx),
      .wb_rd_data            (wb_rd_data),
      .fill_we               (fill_we),
      .fill_sel              (fill_sel),
      .fill_idx              (fill_idx),
      .fill_data             (fill_data),
      .mem_req               (mem_req),
      .mem_we                (mem_we),
      .mem_addr              (mem_addr),
      .mem_wdata             (mem_wdata),
      .mem_ack               (mem_ack),
      .mem_rdata             (mem_rdata)
   );

   always #5 clk_l2 = ~clk_l2;

   // L2 array contents, synchronous read (data one cycle after idx).
   logic [31:0] arr [2][4];
   always @(posedge clk_l2) wb_rd_data <= arr[wb_rd_sel][wb_rd_idx];

   typedef struct {
      logic        done;
      logic        sel;
      logic        fill;
      int          idx;
      logic [31:0] addr;
      logic [31:0] data;
   } op_t;

   op_t exp_q[$];
   int  n_assert = 0;
   int  n_fail   = 0;
   int  gap      = 0;
   int  wctr     = 0;
   int  acks     = 0;
   bit  stray    = 0;
   bit  done_due = 0;
   bit  m_rr     = 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One expected line: LINE_WORDS word ops, then the done pulse.
   task automatic push_line(input bit sel, input bit fill,
                            input logic [31:0] raw);
      logic [31:0] base;
      op_t o;
      base = raw & 32'hFFFF_FFF0;
      for (int i = 0; i < 4; i++) begin
         o.done = 1'b0;
         o.sel  = sel;
         o.fill = fill;
         o.idx  = i;
         o.addr = base + 32'(i * 4);
         o.data = fill ? 32'h0 : arr[sel][i];
         exp_q.push_back(o);
      end
      o.done = 1'b1;
      o.idx  = 0;
      o.addr = '0;
      o.data = '0;
      exp_q.push_back(o);
      m_rr = ~sel;
   endtask

   task automatic cycle();
      logic [3:0]  dv, dexp;
      logic [31:0] rd;
      bit          ack, opv, fexp;
      @(negedge clk_l2);
      dv = {data_mem_replace_done, data_mem_dirty_done,
            inst_mem_replace_done, inst_mem_dirty_done};
      dexp = '0;
      if (done_due)
         dexp = 4'b0001 << {exp_q[0].sel, exp_q[0].fill};
      chk("done", {60'd0, dv}, {60'd0, dexp});
      if (done_due) begin
         void'(exp_q.pop_front());
         done_due = 0;
      end
      opv = (exp_q.size() > 0) && !exp_q[0].done;
      if (!opv) chk("mem_req_idle", {63'd0, mem_req}, 64'd0);
      if (mem_req && opv) begin
         chk("mem_addr", {32'd0, mem_addr}, {32'd0, exp_q[0].addr});
         chk("mem_we", {63'd0, mem_we}, {63'd0, !exp_q[0].fill});
         if (!exp_q[0].fill)
            chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, exp_q[0].data});
      end
      if (mem_req) begin
         if (wctr == 0) begin
            ack  = 1;
            wctr = gap;
         end else begin
            ack  = 0;
            wctr--;
         end
      end else begin
         ack  = stray ? ($urandom_range(0, 1) == 1) : 0;
         wctr = gap;
      end
      rd        = $urandom;
      mem_ack   = ack;
      mem_rdata = rd;
      #1;
      fexp = mem_req && ack && opv && exp_q[0].fill;
      chk("fill_we", {63'd0, fill_we}, {63'd0, fexp});
      if (fexp) begin
         chk("fill_sel", {63'd0, fill_sel}, {63'd0, exp_q[0].sel});
         chk("fill_idx", {62'd0, fill_idx}, 64'(exp_q[0].idx));
         chk("fill_data", {32'd0, fill_data}, {32'd0, rd});
      end
      if (mem_req && ack && opv) begin
         void'(exp_q.pop_front());
         acks++;
         if (exp_q.size() > 0 && exp_q[0].done) done_due = 1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      chk("timeout_idle", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_quiet();
      chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
      chk("rst_fill_we", {63'd0, fill_we}, 64'd0);
      chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      chk("rst_wb_rd", {61'd0, wb_rd_sel, wb_rd_idx}, 64'd0);
      chk("rst_done", {60'd0, data_mem_replace_done, data_mem_dirty_done,
                       inst_mem_replace_done, inst_mem_dirty_done}, 64'd0);
   endtask

   task automatic set_req(input int idx, input logic v,
                          input logic [31:0] a);
      case (idx)
         0: begin inst_mem_dirty_req   = v; inst_dirty_addr = a; end
         1: begin inst_mem_replace_req = v; inst_fill_addr  = a; end
         2: begin data_mem_dirty_req   = v; data_dirty_addr = a; end
         default: begin data_mem_replace_req = v; data_fill_addr = a; end
      endcase
   endtask

   // Pulse one request; scramble its address bus afterwards so the
   // DUT must rely on its latched copy.
   task automatic pulse(input bit sel, input bit fill,
                        input logic [31:0] a);
      set_req({sel, fill}, 1'b1, a);
      cycle();
      set_req({sel, fill}, 1'b0, $urandom);
   endtask

   task automatic rand_arr();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 4; i++) arr[s][i] = $urandom;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      exp_q.delete();
      done_due = 0;
      chk_quiet();
      cycle();
      rst  = 1'b0;
      m_rr = 1;
   endtask

   initial begin
      bit          s, f, f2, first;
      logic [31:0] a, a2;
      rst = 1'b1;
      mem_ack = 0;
      mem_rdata = '0;
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h0);
      rand_arr();

      // Level held through reset must not be captured.
      set_req(2, 1'b1, 32'h1000_0014);
      do_reset();
      repeat (5) cycle();
      set_req(2, 1'b0, 32'h1000_0014);
      cycle();

      // Data writeback, ack every cycle.
      gap = 0;
      push_line(1, 0, 32'h1000_0014);
      set_req(2, 1'b1, 32'h1000_0014);
      wait_idle(100);
      set_req(2, 1'b0, 32'h1000_0014);
      cycle();

      // Inst fill, one-cycle pulse, acks with 2-cycle gaps.
      gap = 2;
      push_line(0, 1, 32'h2000_0040);
      pulse(0, 1, 32'h2000_0040);
      wait_idle(100);

      // Simultaneous dirty edges after reset: data first.
      gap = 0;
      do_reset();
      cycle();
      rand_arr();
      push_line(1, 0, 32'h3000_0100);
      push_line(0, 0, 32'h4000_0200);
      set_req(0, 1'b1, 32'h4000_0200);
      set_req(2, 1'b1, 32'h3000_0100);
      cycle();
      set_req(0, 1'b0, 32'h0);
      set_req(2, 1'b0, 32'h0);
      wait_idle(200);

      // Dirty held past done, then a fill pulse.
      gap = 1;
      rand_arr();
      push_line(0, 0, 32'h5000_0030);
      set_req(0, 1'b1, 32'h5000_0030);
      wait_idle(100);
      cycle();
      set_req(0, 1'b0, 32'h0);
      push_line(0, 1, 32'h6000_0070);
      pulse(0, 1, 32'h6000_0070);
      wait_idle(100);
      repeat (3) cycle();

      // Reset in the middle of a fill.
      gap  = 0;
      acks = 0;
      push_line(1, 1, 32'h7000_0120);
      pulse(1, 1, 32'h7000_0120);
      for (int n = 0; n < 50 && acks < 2; n++) cycle();
      chk("acks_before_rst", 64'(acks), 64'd2);
      do_reset();
      repeat (3) cycle();
      push_line(1, 1, 32'h7000_0120);
      pulse(1, 1, 32'h7000_0120);
      wait_idle(100);

      // Random single requests, stray acks while idle.
      stray = 1;
      for (int k = 0; k < 6; k++) begin
         s   = $urandom_range(0, 1);
         f   = $urandom_range(0, 1);
         a   = $urandom;
         gap = $urandom_range(0, 2);
         rand_arr();
         push_line(s, f, a);
         pulse(s, f, a);
         wait_idle(200);
         repeat ($urandom_range(0, 3)) cycle();
      end

      // Random inst/data pairs in the same cycle, round-robin order.
      for (int k = 0; k < 3; k++) begin
         f   = $urandom_range(0, 1);
         f2  = $urandom_range(0, 1);
         a   = $urandom;
         a2  = $urandom;
         gap = $urandom_range(0, 1);
         rand_arr();
         first = m_rr;
         if (first) begin
            push_line(1, f2, a2);
            push_line(0, f, a);
         end else begin
            push_line(0, f, a);
            push_line(1, f2, a2);
         end
         set_req({1'b0, f}, 1'b1, a);
         set_req({1'b1, f2}, 1'b1, a2);
         cycle();
         set_req({1'b0, f}, 1'b0, $urandom);
         set_req({1'b1, f2}, 1'b0, $urandom);
         wait_idle(300);
         cycle();
      end

      stray = 0;
      repeat (4) cycle();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
